// File: rtl/rvvi_fifo_pkg.sv
// Shared RVVI record definitions and FIFO sizing defaults.
// Used by the record generator, rvvi_fifo and the Ethernet packetizer.
package rvvi_fifo_pkg;

    localparam int RVVI_XLEN     = 64;
    localparam int RVVI_MAX_CSRS = 5;

    // Fixed header, five XLEN-wide fields, then one (value, address) slot per CSR.
    localparam int RVVI_DATA_WIDTH = 72 + 5 * RVVI_XLEN + RVVI_MAX_CSRS * (RVVI_XLEN + 16);

    localparam int RVVI_FIFO_DEPTH_DEFAULT = 16;
    localparam int RVVI_FIFO_SKID_DEFAULT  = 4;

    typedef logic [RVVI_DATA_WIDTH-1:0] rvvi_rec_t;

    // Circular increment for an array whose size need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned entries);
        return (ptr == entries - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rvvi_fifo_ram.sv
// Simple dual-port record array: one synchronous write port and one
// asynchronous read port, so it maps onto FPGA distributed RAM.
module rvvi_fifo_ram #(
    parameter int DATA_WIDTH = 792,
    parameter int ENTRIES    = 15,
    parameter int PTR_W      = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    // Record storage write port.
    // NOTE: the array has no reset; entries are only read after being written, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rvvi_fifo.sv
// Elastic buffer between the RVVI record generator and the packetizer.
// DEPTH-1 array entries plus a first-word-fall-through output register.
// Optional build macro RVVI_FIFO_STATS_EN adds HighWater and DropCount outputs.
module rvvi_fifo
    import rvvi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RVVI_DATA_WIDTH,
    parameter int DEPTH      = RVVI_FIFO_DEPTH_DEFAULT,
    parameter int SKID       = RVVI_FIFO_SKID_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    InValid,
    input  logic [DATA_WIDTH-1:0]   InRvvi,
    output logic                    OutValid,
    output logic [DATA_WIDTH-1:0]   OutRvvi,
    input  logic                    OutReady,
    output logic                    Stall,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Overflow
`ifdef RVVI_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]  HighWater,
    output logic [31:0]             DropCount
`endif
);

    localparam int ENTRIES = DEPTH - 1;
    localparam int PTR_W   = $clog2(ENTRIES);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  stall_q, stall_d;
    logic                  overflow_q, overflow_d;

    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  arr_empty;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    rvvi_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (ENTRIES),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (InRvvi),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Next-state: handshake decode, output register steering, pointers, count and stall.
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pop       = out_valid_q & OutReady;
        // A full FIFO still accepts when the head leaves on the same edge.
        push      = InValid & ((count_q != FULL_CNT) | pop);
        drop      = InValid & ~push;
        // The output register holds the head, so the array is empty at Count <= 1.
        arr_empty = (count_q <= ONE_CNT);

        ram_we      = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (!out_valid_q) begin
            // Empty: bypass straight into the output register.
            if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = InRvvi;
            end
        end else if (pop) begin
            if (!arr_empty) begin
                // Refill from the array head; when full, the write lands in the slot being vacated.
                out_data_d = ram_rdata;
                rd_ptr_d   = PTR_W'(next_ptr(32'(rd_ptr_q), ENTRIES));
                if (push) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), ENTRIES));
                end
            end else if (push) begin
                out_data_d = InRvvi;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            ram_we   = 1'b1;
            wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), ENTRIES));
        end

        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        stall_d    = (count_d >= STALL_CNT);
        overflow_d = overflow_q | drop;
    end

    // State registers; reset discards all held records.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
        end
    end

    assign OutValid = out_valid_q;
    assign OutRvvi  = out_data_q;
    assign Count    = count_q;
    assign Stall    = stall_q;
    assign Overflow = overflow_q;

`ifdef RVVI_FIFO_STATS_EN
    logic [CNT_W-1:0] high_water_q, high_water_d;
    logic [31:0]      drop_count_q, drop_count_d;

    // Statistics next-state: occupancy peak and saturating drop count.
    always_comb begin
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
        drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + 32'd1 : drop_count_q;
    end

    // Statistics registers, updated on the same edge as Count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_water_q <= '0;
            drop_count_q <= '0;
        end else begin
            high_water_q <= high_water_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign HighWater = high_water_q;
    assign DropCount = drop_count_q;
`endif

endmodule

// File: tb/tb_rvvi_fifo.sv
// Self-checking bench for rvvi_fifo at DEPTH=8, SKID=2 with a queue-based reference model.
module tb_rvvi_fifo;

    localparam int DW    = 792;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          InValid;
    logic [DW-1:0] InRvvi;
    logic          OutValid;
    logic [DW-1:0] OutRvvi;
    logic          OutReady;
    logic          Stall;
    logic [CW-1:0] Count;
    logic          Overflow;
`ifdef RVVI_FIFO_STATS_EN
    logic [CW-1:0] HighWater;
    logic [31:0]   DropCount;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            exp_ovf;
    bit            exp_stall;
    int            exp_hw;
    longint        exp_drops;

    rvvi_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InRvvi   (InRvvi),
        .OutValid (OutValid),
        .OutRvvi  (OutRvvi),
        .OutReady (OutReady),
        .Stall    (Stall),
        .Count    (Count),
        .Overflow (Overflow)
`ifdef RVVI_FIFO_STATS_EN
        ,
        .HighWater(HighWater),
        .DropCount(DropCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_rec();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW / 32 + 1; i++) r = {r[DW-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_ovf   = 1'b0;
        exp_stall = 1'b0;
        exp_hw    = 0;
        exp_drops = 0;
    endtask

    // Apply one cycle of inputs, advance the model by one edge, land #1 after the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy);
        bit pop_m;
        bit acc_m;
        InValid  = v;
        InRvvi   = d;
        OutReady = rdy;
        @(posedge clk);
        pop_m = (mq.size() > 0) && rdy;
        acc_m = v && ((mq.size() < DEPTH) || pop_m);
        if (pop_m) void'(mq.pop_front());
        if (acc_m) mq.push_back(d);
        else if (v) begin
            exp_ovf = 1'b1;
            if (exp_drops < 64'hFFFF_FFFF) exp_drops++;
        end
        exp_stall = (mq.size() >= DEPTH - SKID);
        if (mq.size() > exp_hw) exp_hw = mq.size();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; InValid = 1'b0; InRvvi = '0; OutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_outvalid act=%0b exp=0", OutValid); end
        vectors++; if (Count !== '0) begin miscompares++; $display("FAIL reset_count act=%0d exp=0", Count); end
        vectors++; if (Stall !== 1'b0 || Overflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags stall=%0b ovf=%0b exp=0,0", Stall, Overflow); end
        vectors++; if (OutRvvi !== '0) begin miscompares++; $display("FAIL reset_outrvvi act=%0h exp=0", OutRvvi); end
        reset = 1'b0;
    endtask

    task automatic test_first_write();
        logic [DW-1:0] rec;
        rec = {(DW/8){8'hA5}};
        cycle(1'b1, rec, 1'b0);
        vectors++; if (OutValid !== 1'b1) begin miscompares++; $display("FAIL first_outvalid act=%0b exp=1", OutValid); end
        vectors++; if (OutRvvi !== rec) begin miscompares++; $display("FAIL first_outrvvi act=%0h exp=%0h", OutRvvi, rec); end
        vectors++; if (Count !== CW'(1)) begin miscompares++; $display("FAIL first_count act=%0d exp=1", Count); end
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL first_stall act=%0b exp=0", Stall); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(1'b1, rand_rec(), 1'b0);
            vectors++; if (Count !== CW'(mq.size())) begin miscompares++; $display("FAIL fill_count act=%0d exp=%0d", Count, mq.size()); end
            vectors++; if (Stall !== exp_stall) begin miscompares++; $display("FAIL fill_stall count=%0d act=%0b exp=%0b", Count, Stall, exp_stall); end
            vectors++; if (OutRvvi !== mq[0]) begin miscompares++; $display("FAIL fill_head_stable act=%0h exp=%0h", OutRvvi, mq[0]); end
        end
        vectors++; if (Count !== CW'(8)) begin miscompares++; $display("FAIL fill_full_count act=%0d exp=8", Count); end
        vectors++; if (Overflow !== 1'b0) begin miscompares++; $display("FAIL fill_overflow act=%0b exp=0", Overflow); end
    endtask

    task automatic test_drop();
        cycle(1'b1, rand_rec(), 1'b0);
        vectors++; if (Overflow !== 1'b1) begin miscompares++; $display("FAIL drop_overflow act=%0b exp=1", Overflow); end
        vectors++; if (Count !== CW'(8)) begin miscompares++; $display("FAIL drop_count act=%0d exp=8", Count); end
        vectors++; if (OutRvvi !== mq[0]) begin miscompares++; $display("FAIL drop_head act=%0h exp=%0h", OutRvvi, mq[0]); end
`ifdef RVVI_FIFO_STATS_EN
        vectors++; if (DropCount !== 32'd1) begin miscompares++; $display("FAIL drop_dropcount act=%0d exp=1", DropCount); end
        vectors++; if (HighWater !== CW'(8)) begin miscompares++; $display("FAIL drop_highwater act=%0d exp=8", HighWater); end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] last;
        last = rand_rec();
        cycle(1'b1, last, 1'b1);
        vectors++; if (Count !== CW'(8)) begin miscompares++; $display("FAIL fullpp_count act=%0d exp=8", Count); end
`ifdef RVVI_FIFO_STATS_EN
        vectors++; if (DropCount !== 32'(exp_drops)) begin miscompares++; $display("FAIL fullpp_dropcount act=%0d exp=%0d", DropCount, exp_drops); end
`endif
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
            vectors++; if (OutValid !== 1'b1 || OutRvvi !== mq[0]) begin miscompares++; $display("FAIL drain_order step=%0d v=%0b act=%0h exp=%0h", i, OutValid, OutRvvi, mq[0]); end
            if (mq.size() == 1) begin
                vectors++; if (OutRvvi !== last) begin miscompares++; $display("FAIL drain_last act=%0h exp=%0h", OutRvvi, last); end
            end
            cycle(1'b0, '0, 1'b1);
            vectors++; if (Stall !== exp_stall) begin miscompares++; $display("FAIL drain_stall act=%0b exp=%0b", Stall, exp_stall); end
        end
        vectors++; if (OutValid !== 1'b0 || Count !== '0) begin miscompares++; $display("FAIL drain_empty v=%0b count=%0d exp=0,0", OutValid, Count); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] rec;
        logic [DW-1:0] held;
        bit            rdy;
        bit            v;
        int            written;
        int            peak;
        written = 0;
        peak    = 0;
        for (int i = 0; i < 400 && (written < 100 || sent.size() > 0); i++) begin
            rdy = (i % 2 == 0);
            v   = !rdy && (written < 100);
            rec = rand_rec();
            held = OutRvvi;
            if (OutValid && rdy) begin
                vectors++; if (OutRvvi !== sent[0]) begin miscompares++; $display("FAIL stream_order idx=%0d act=%0h exp=%0h", written - sent.size(), OutRvvi, sent[0]); end
                void'(sent.pop_front());
            end
            if (v) begin sent.push_back(rec); written++; end
            cycle(v, rec, rdy);
            if (!rdy && OutValid && mq.size() > 1) begin
                vectors++; if (OutRvvi !== held) begin miscompares++; $display("FAIL stream_stable act=%0h exp=%0h", OutRvvi, held); end
            end
            if (int'(Count) > peak) peak = int'(Count);
            vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL stream_stall act=%0b exp=0", Stall); end
            vectors++; if (Count !== CW'(mq.size())) begin miscompares++; $display("FAIL stream_count act=%0d exp=%0d", Count, mq.size()); end
        end
        vectors++; if (written != 100 || sent.size() != 0) begin miscompares++; $display("FAIL stream_complete written=%0d pending=%0d exp=100,0", written, sent.size()); end
        vectors++; if (peak > 2) begin miscompares++; $display("FAIL stream_peak act=%0d exp<=2", peak); end
    endtask

    task automatic test_random();
        bit v;
        bit rdy;
        int bias;
        for (int i = 0; i < 600; i++) begin
            bias = (i / 150) % 2 == 0 ? 3 : 8;
            v    = ($urandom_range(9) < 6);
            rdy  = ($urandom_range(9) < bias);
            cycle(v, rand_rec(), rdy);
            vectors++; if (OutValid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rand_outvalid cyc=%0d act=%0b exp=%0b", i, OutValid, mq.size() > 0); end
            vectors++; if (Count !== CW'(mq.size())) begin miscompares++; $display("FAIL rand_count cyc=%0d act=%0d exp=%0d", i, Count, mq.size()); end
            vectors++; if (Stall !== exp_stall || Overflow !== exp_ovf) begin miscompares++; $display("FAIL rand_flags cyc=%0d stall=%0b/%0b ovf=%0b/%0b", i, Stall, exp_stall, Overflow, exp_ovf); end
            if (mq.size() > 0) begin
                vectors++; if (OutRvvi !== mq[0]) begin miscompares++; $display("FAIL rand_head cyc=%0d act=%0h exp=%0h", i, OutRvvi, mq[0]); end
            end
`ifdef RVVI_FIFO_STATS_EN
            vectors++; if (HighWater !== CW'(exp_hw) || DropCount !== 32'(exp_drops)) begin miscompares++; $display("FAIL rand_stats cyc=%0d hw=%0d/%0d drops=%0d/%0d", i, HighWater, exp_hw, DropCount, exp_drops); end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] rec;
        for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_rec(), 1'b0);
        vectors++; if (Count !== CW'(5)) begin miscompares++; $display("FAIL mid_precount act=%0d exp=5", Count); end
        InValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if (OutValid !== 1'b0 || Count !== '0) begin miscompares++; $display("FAIL mid_reset_async v=%0b count=%0d exp=0,0", OutValid, Count); end
        vectors++; if (Stall !== 1'b0 || Overflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset_flags stall=%0b ovf=%0b exp=0,0", Stall, Overflow); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        rec = rand_rec();
        cycle(1'b1, rec, 1'b0);
        vectors++; if (OutValid !== 1'b1 || OutRvvi !== rec) begin miscompares++; $display("FAIL mid_post_write v=%0b act=%0h exp=%0h", OutValid, OutRvvi, rec); end
        vectors++; if (Count !== CW'(1)) begin miscompares++; $display("FAIL mid_post_count act=%0d exp=1", Count); end
`ifdef RVVI_FIFO_STATS_EN
        vectors++; if (DropCount !== 32'd0 || HighWater !== CW'(1)) begin miscompares++; $display("FAIL mid_post_stats hw=%0d drops=%0d exp=1,0", HighWater, DropCount); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_fill();
        test_drop();
        test_full_push_pop();
        test_stream();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
